// File: rtl/motor_pkg.sv
// Shared types and constants for the SPI-driven pan/tilt stepper controller.
package motor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PULSE,
        GAP
    } axis_state_t;

    localparam int ETC_STOP_BIT = 0;
    localparam int ETC_HOLD_BIT = 1;

    // Wide enough for the largest axis magnitude (|-128| = 128).
    localparam int MAG_W = 9;

    typedef struct packed {
        logic [MAG_W-1:0] mag;
        logic             dir;
    } cmd_t;

endpackage

// File: rtl/motor_axis.sv
// One stepper axis: pending-command slot, IDLE/SETUP/PULSE/GAP sequencer, step/dir/busy.
module motor_axis
    import motor_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int STEP_HIGH   = 100,
    parameter int STEP_PERIOD = 1000,
    parameter int DIR_SETUP   = 50
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stop,
    input  logic            cmd_valid,
    input  logic [DATA_W:0] cmd_mag,
    input  logic            cmd_dir,
    output logic            step,
    output logic            dir,
    output logic            busy
);

    localparam int CNT_W   = $clog2(STEP_PERIOD);
    localparam int SETUP_W = $clog2(DIR_SETUP + 1);

    axis_state_t        state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [MAG_W-1:0]   remaining;
    logic [SETUP_W-1:0] setup_left;
    cmd_t               pend;
    logic               pend_valid;
    logic               load;
    logic               dir_flip;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // A zero-magnitude command is absorbed in IDLE without touching dir.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        dir_flip   = 1'b0;
        case (state)
            IDLE: begin
                if (pend_valid) begin
                    load = 1'b1;
                    if (pend.mag == '0) begin
                        state_next = IDLE;
                    end else if (pend.dir != dir || setup_left != '0) begin
                        dir_flip   = (pend.dir != dir);
                        state_next = SETUP;
                    end else begin
                        state_next = PULSE;
                    end
                end
            end
            SETUP: if (setup_left <= SETUP_W'(1)) state_next = PULSE;
            PULSE: if (cnt == CNT_W'(STEP_HIGH - 1)) state_next = GAP;
            GAP: begin
                if (cnt == CNT_W'(STEP_PERIOD - 1)) begin
                    if (pend_valid)            state_next = IDLE;
                    else if (remaining != '0)  state_next = PULSE;
                    else                       state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (stop) state_next = IDLE;
        step = (state == PULSE);
        busy = (state != IDLE) || pend_valid;
    end

    // cnt runs from the rising step edge through the whole GAP, so one counter times the period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            remaining  <= '0;
            dir        <= 1'b0;
            setup_left <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (setup_left != '0) setup_left <= setup_left - SETUP_W'(1);
            if (stop) begin
                cnt        <= '0;
                remaining  <= '0;
                pend_valid <= 1'b0;
            end else begin
                if (state == PULSE || (state == GAP && state_next == GAP)) cnt <= cnt + CNT_W'(1);
                else                                                       cnt <= '0;
                if (state == PULSE && state_next == GAP) remaining <= remaining - MAG_W'(1);
                if (load) begin
                    pend_valid <= 1'b0;
                    remaining  <= pend.mag;
                    if (dir_flip) begin
                        dir        <= pend.dir;
                        setup_left <= SETUP_W'(DIR_SETUP);
                    end
                end
                if (cmd_valid) begin
                    pend_valid <= 1'b1;
                    pend       <= '{mag: MAG_W'(cmd_mag), dir: cmd_dir};
                end
            end
        end
    end

endmodule

// File: rtl/spi_motor_ctrl.sv
// Decodes SPI MOSI frames into pan/tilt step commands and drives two motor_axis engines.
// Optional link watchdog enabled by defining MOTOR_WDT_EN.
module spi_motor_ctrl
    import motor_pkg::*;
#(
    parameter int STEP_HIGH   = 100,
    parameter int STEP_PERIOD = 1000,
    parameter int DIR_SETUP   = 50,
    parameter int WDT_CYCLES  = 10_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  mortor_xdata,
    input  logic [6:0]  mortor_ydata,
    input  logic [16:0] mosi_etc,
    input  logic        mosi_valid,
    output logic        x_step,
    output logic        y_step,
    output logic        x_dir,
    output logic        y_dir,
    output logic        x_busy,
    output logic        y_busy,
    output logic        wdt_fault
);

    logic       frame_stop;
    logic       cmd_valid;
    logic       axis_stop;
    logic       wdt_stop;
    logic [8:0] x_ext, x_mag;
    logic [7:0] y_ext, y_mag;
    logic       unused_etc;

    assign unused_etc = ^mosi_etc[16:2];

    assign frame_stop = mosi_valid && mosi_etc[ETC_STOP_BIT];
    assign cmd_valid  = mosi_valid && !mosi_etc[ETC_STOP_BIT] && !mosi_etc[ETC_HOLD_BIT] && !wdt_fault;
    assign axis_stop  = frame_stop || wdt_stop;

    // Sign-extend one bit first so |-128| and |-64| fit without overflow.
    assign x_ext = {mortor_xdata[7], mortor_xdata};
    assign y_ext = {mortor_ydata[6], mortor_ydata};
    assign x_mag = x_ext[8] ? (~x_ext + 9'd1) : x_ext;
    assign y_mag = y_ext[7] ? (~y_ext + 8'd1) : y_ext;

`ifdef MOTOR_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES);

    logic [WDT_W-1:0] wdt_cnt;
    logic             wdt_trip;
    logic             fault_q;

    assign wdt_trip  = !mosi_valid && !fault_q && (wdt_cnt == WDT_W'(WDT_CYCLES - 1));
    assign wdt_stop  = wdt_trip || fault_q;
    assign wdt_fault = fault_q;

    // The counter freezes once tripped; only a STOP frame (or reset) re-arms the link.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdt_cnt <= '0;
            fault_q <= 1'b0;
        end else if (mosi_valid) begin
            wdt_cnt <= '0;
            if (frame_stop) fault_q <= 1'b0;
        end else if (wdt_trip) begin
            fault_q <= 1'b1;
        end else if (!fault_q) begin
            wdt_cnt <= wdt_cnt + WDT_W'(1);
        end
    end
`else
    logic unused_wdt;

    assign unused_wdt = (WDT_CYCLES == 0);
    assign wdt_stop   = 1'b0;
    assign wdt_fault  = 1'b0;
`endif

    motor_axis #(
        .DATA_W      (8),
        .STEP_HIGH   (STEP_HIGH),
        .STEP_PERIOD (STEP_PERIOD),
        .DIR_SETUP   (DIR_SETUP)
    ) u_x_axis (
        .clk       (clk),
        .reset     (reset),
        .stop      (axis_stop),
        .cmd_valid (cmd_valid),
        .cmd_mag   (x_mag),
        .cmd_dir   (mortor_xdata[7]),
        .step      (x_step),
        .dir       (x_dir),
        .busy      (x_busy)
    );

    motor_axis #(
        .DATA_W      (7),
        .STEP_HIGH   (STEP_HIGH),
        .STEP_PERIOD (STEP_PERIOD),
        .DIR_SETUP   (DIR_SETUP)
    ) u_y_axis (
        .clk       (clk),
        .reset     (reset),
        .stop      (axis_stop),
        .cmd_valid (cmd_valid),
        .cmd_mag   (y_mag),
        .cmd_dir   (mortor_ydata[6]),
        .step      (y_step),
        .dir       (y_dir),
        .busy      (y_busy)
    );

endmodule

// File: tb/tb_spi_motor_ctrl.sv
// Self-checking bench for spi_motor_ctrl: table vectors, randomized frames vs. a pulse-count model,
// and directed corner cases. With MOTOR_WDT_EN defined it runs the watchdog sequence instead.
module tb_spi_motor_ctrl;

    localparam int STEP_HIGH   = 3;
    localparam int STEP_PERIOD = 10;
    localparam int DIR_SETUP   = 4;
    localparam int WDT_CYCLES  = 50;
    localparam logic [16:0] ETC_STOP = 17'h1;
    localparam logic [16:0] ETC_HOLD = 17'h2;

    logic        clk;
    logic        reset;
    logic [7:0]  mortor_xdata;
    logic [6:0]  mortor_ydata;
    logic [16:0] mosi_etc;
    logic        mosi_valid;
    logic        x_step, y_step, x_dir, y_dir, x_busy, y_busy, wdt_fault;

    int vectors;
    int miscompares;

    spi_motor_ctrl #(
        .STEP_HIGH   (STEP_HIGH),
        .STEP_PERIOD (STEP_PERIOD),
        .DIR_SETUP   (DIR_SETUP),
        .WDT_CYCLES  (WDT_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mortor_xdata (mortor_xdata),
        .mortor_ydata (mortor_ydata),
        .mosi_etc     (mosi_etc),
        .mosi_valid   (mosi_valid),
        .x_step       (x_step),
        .y_step       (y_step),
        .x_dir        (x_dir),
        .y_dir        (y_dir),
        .x_busy       (x_busy),
        .y_busy       (y_busy),
        .wdt_fault    (wdt_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse monitor: cycle index of every rising step edge and a count of pulses whose width is wrong.
    int   cyc;
    int   x_rises[$];
    int   y_rises[$];
    int   x_bad_width, y_bad_width;
    int   x_hi, y_hi;
    int   wdt_cyc;
    logic x_prev, y_prev, wdt_prev;

    initial begin
        cyc = 0; x_hi = 0; y_hi = 0; wdt_cyc = -1;
        x_bad_width = 0; y_bad_width = 0;
        x_prev = 1'b0; y_prev = 1'b0; wdt_prev = 1'b0;
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        if (x_step && !x_prev) x_rises.push_back(cyc);
        if (y_step && !y_prev) y_rises.push_back(cyc);
        if (x_step) x_hi++;
        else begin
            if (x_prev && x_hi != STEP_HIGH) x_bad_width++;
            x_hi = 0;
        end
        if (y_step) y_hi++;
        else begin
            if (y_prev && y_hi != STEP_HIGH) y_bad_width++;
            y_hi = 0;
        end
        if (wdt_fault && !wdt_prev) wdt_cyc = cyc;
        x_prev   = x_step;
        y_prev   = y_step;
        wdt_prev = wdt_fault;
    end

    typedef struct {
        logic [7:0]  x;
        logic [6:0]  y;
        logic [16:0] etc;
        int          x_pulses;
        logic        x_dir;
        int          y_pulses;
        logic        y_dir;
    } vec_t;

    vec_t vec_table[8];
    int   frame_cyc;

    task automatic check_output(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic clear_monitor();
        x_rises.delete();
        y_rises.delete();
        x_bad_width = 0;
        y_bad_width = 0;
    endtask

    // One-cycle frame; frame_cyc is the index of the edge that samples mosi_valid.
    task automatic apply_stimulus(input logic [7:0] x, input logic [6:0] y, input logic [16:0] etc);
        @(negedge clk);
        mortor_xdata = x;
        mortor_ydata = y;
        mosi_etc     = etc;
        mosi_valid   = 1'b1;
        @(negedge clk);
        mosi_valid   = 1'b0;
        mortor_xdata = '0;
        mortor_ydata = '0;
        mosi_etc     = '0;
        frame_cyc    = cyc;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int count_bad_periods(input int rises[$]);
        int bad = 0;
        for (int i = 1; i < rises.size(); i++)
            if (rises[i] - rises[i-1] != STEP_PERIOD) bad++;
        return bad;
    endfunction

    // Sends one frame to idle axes and checks the complete pulse train it produces.
    task automatic run_vector(input string tag, input logic [7:0] x, input logic [6:0] y,
                              input logic [16:0] etc, input int exp_xp, input logic exp_xd,
                              input int exp_yp, input logic exp_yd,
                              input logic prev_xd, input logic prev_yd);
        int budget;
        clear_monitor();
        apply_stimulus(x, y, etc);
        budget = 3000;
        while ((x_busy || y_busy) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_output({tag, " idle timeout"}, int'(x_busy || y_busy), 0);
        check_output({tag, " x pulses"}, x_rises.size(), exp_xp);
        check_output({tag, " x_dir"}, int'(x_dir), int'(exp_xd));
        check_output({tag, " y pulses"}, y_rises.size(), exp_yp);
        check_output({tag, " y_dir"}, int'(y_dir), int'(exp_yd));
        check_output({tag, " bad widths"}, x_bad_width + y_bad_width, 0);
        check_output({tag, " bad periods"}, count_bad_periods(x_rises) + count_bad_periods(y_rises), 0);
        if (exp_xp > 0 && x_rises.size() > 0)
            check_output({tag, " x first rise"}, x_rises[0],
                         frame_cyc + 1 + ((exp_xd != prev_xd) ? DIR_SETUP : 0));
        if (exp_yp > 0 && y_rises.size() > 0)
            check_output({tag, " y first rise"}, y_rises[0],
                         frame_cyc + 1 + ((exp_yd != prev_yd) ? DIR_SETUP : 0));
    endtask

    task automatic wait_x_rises(input string tag, input int n, input logic level);
        int budget = 2000;
        while (!(x_rises.size() >= n && x_step == level) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_output({tag, " wait"}, int'(x_rises.size() >= n && x_step == level), 1);
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, " x_step"}, int'(x_step), 0);
        check_output({tag, " y_step"}, int'(y_step), 0);
        check_output({tag, " x_dir"}, int'(x_dir), 0);
        check_output({tag, " y_dir"}, int'(y_dir), 0);
        check_output({tag, " x_busy"}, int'(x_busy), 0);
        check_output({tag, " y_busy"}, int'(y_busy), 0);
        check_output({tag, " wdt_fault"}, int'(wdt_fault), 0);
    endtask

    initial begin
        logic        mxd, myd, accepted;
        int          xv, yv, r, exp_xp, exp_yp, n, h;
        logic [16:0] etc;

        vectors = 0; miscompares = 0;
        reset = 1'b0; mosi_valid = 1'b0;
        mortor_xdata = '0; mortor_ydata = '0; mosi_etc = '0;

        vec_table[0] = '{8'd3,   7'd0,   17'h0,     3,   1'b0, 0,  1'b0};
        vec_table[1] = '{8'h80,  7'h40,  17'h0,     128, 1'b1, 64, 1'b1};
        vec_table[2] = '{8'd5,   7'h3f,  17'h0,     5,   1'b0, 63, 1'b0};
        vec_table[3] = '{8'd7,   7'd5,   ETC_HOLD,  0,   1'b0, 0,  1'b0};
        vec_table[4] = '{8'hff,  7'd0,   17'h0,     1,   1'b1, 0,  1'b0};
        vec_table[5] = '{8'd0,   7'h7f,  17'h0,     0,   1'b1, 1,  1'b1};
        vec_table[6] = '{8'd9,   7'd9,   17'h3,     0,   1'b1, 0,  1'b1};
        vec_table[7] = '{8'd2,   7'd2,   17'h1fffc, 2,   1'b0, 2,  1'b0};

        #12;
        check_reset_state("in reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("after reset");

`ifdef MOTOR_WDT_EN
        clear_monitor();
        apply_stimulus(8'd100, 7'd0, 17'h0);
        n = frame_cyc;
        h = 200;
        while (!wdt_fault && h > 0) begin @(negedge clk); h--; end
        check_output("wdt trip cycle", wdt_cyc, n + WDT_CYCLES);
        check_output("wdt x_step", int'(x_step), 0);
        check_output("wdt x_busy", int'(x_busy), 0);
        check_output("wdt pulses before trip", x_rises.size(), 5);
        apply_stimulus(8'd2, 7'd0, 17'h0);
        wait_cycles(30);
        check_output("wdt ignored cmd pulses", x_rises.size(), 5);
        check_output("wdt ignored cmd busy", int'(x_busy), 0);
        check_output("wdt still set", int'(wdt_fault), 1);
        apply_stimulus(8'd0, 7'd0, ETC_STOP);
        check_output("wdt cleared by stop", int'(wdt_fault), 0);
        wait_cycles(20);
        apply_stimulus(8'd7, 7'd0, ETC_HOLD);
        n = frame_cyc;
        check_output("wdt hold no fault yet", int'(wdt_fault), 0);
        h = 200;
        while (!wdt_fault && h > 0) begin @(negedge clk); h--; end
        check_output("wdt hold restart", wdt_cyc, n + WDT_CYCLES);
        check_output("wdt hold pulses", x_rises.size(), 5);
`else
        mxd = 1'b0;
        myd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            run_vector($sformatf("vec%0d", i), vec_table[i].x, vec_table[i].y, vec_table[i].etc,
                       vec_table[i].x_pulses, vec_table[i].x_dir,
                       vec_table[i].y_pulses, vec_table[i].y_dir, mxd, myd);
            mxd = vec_table[i].x_dir;
            myd = vec_table[i].y_dir;
        end

        // Random frames: expected pulse count is |value| unless STOP/HOLD; sign sets dir unless value is 0.
        for (int i = 0; i < 12; i++) begin
            xv  = int'($urandom_range(0, 40)) - 20;
            yv  = int'($urandom_range(0, 40)) - 20;
            r   = int'($urandom_range(0, 9));
            etc = {15'($urandom_range(0, 32767)), 2'b00};
            if (r == 0) etc[0] = 1'b1;
            if (r == 1) etc[1] = 1'b1;
            accepted = (r > 1);
            exp_xp = accepted ? ((xv < 0) ? -xv : xv) : 0;
            exp_yp = accepted ? ((yv < 0) ? -yv : yv) : 0;
            run_vector($sformatf("rnd%0d", i), 8'(xv), 7'(yv), etc, exp_xp,
                       (accepted && xv != 0) ? (xv < 0) : mxd, exp_yp,
                       (accepted && yv != 0) ? (yv < 0) : myd, mxd, myd);
            if (accepted && xv != 0) mxd = (xv < 0);
            if (accepted && yv != 0) myd = (yv < 0);
        end

        // Latest command wins at the GAP->IDLE boundary, costing one extra IDLE cycle.
        clear_monitor();
        apply_stimulus(8'd5, 7'd0, 17'h0);
        wait_x_rises("lcw", 2, 1'b0);
        apply_stimulus(8'd1, 7'd0, 17'h0);
        wait_cycles(60);
        check_output("lcw total pulses", x_rises.size(), 3);
        check_output("lcw widths", x_bad_width, 0);
        if (x_rises.size() == 3)
            check_output("lcw reload spacing", x_rises[2] - x_rises[1], STEP_PERIOD + 1);
        check_output("lcw busy", int'(x_busy), 0);
        check_output("lcw y pulses", y_rises.size(), 0);

        // STOP mid-pulse cuts step on the sampling edge and discards the rest.
        clear_monitor();
        apply_stimulus(8'd10, 7'd0, 17'h0);
        wait_x_rises("stop", 3, 1'b1);
        apply_stimulus(8'd0, 7'd0, ETC_STOP);
        check_output("stop x_step", int'(x_step), 0);
        check_output("stop x_busy", int'(x_busy), 0);
        wait_cycles(40);
        check_output("stop no more pulses", x_rises.size(), 3);

        // Asynchronous reset in the middle of a pulse.
        clear_monitor();
        apply_stimulus(8'd4, 7'd0, 17'h0);
        wait_x_rises("areset", 1, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_output("areset x_step", int'(x_step), 0);
        check_output("areset x_busy", int'(x_busy), 0);
        @(negedge clk);
        reset = 1'b1;
        wait_cycles(20);
        check_output("areset no more pulses", x_rises.size(), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
